// File: rtl/mem_stage.sv
// mem_stage: MEM access controller (req/ack data memory, timeout, misalign detect)
// and MEM/WB pipeline register for the 5-stage MIPS pipeline.
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  MEM_M,
    input  logic [1:0]  WB_M,
    input  logic [31:0] ALUOut_M,
    input  logic [31:0] WriteData_M,
    input  logic [4:0]  WriteReg_M,
    output logic        stall_M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [1:0]  WB_W,
    output logic [31:0] ReadData_W,
    output logic [31:0] ALUOut_W,
    output logic [4:0]  WriteReg_W,
    output logic        misalign_W,
    output logic        bus_err_W
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nx;

    logic [CW-1:0] cnt;
    logic [31:0]   cap_addr, cap_wdata;
    logic          cap_we;
    logic [1:0]    cap_wb;
    logic [4:0]    cap_wreg;
    logic          mem_op, aligned, timeout, hold;

    always_comb begin
        mem_op   = |MEM_M;
        aligned  = ALUOut_M[1:0] == 2'b00;
        timeout  = cnt == LAST;
        hold     = (state == IDLE) ? (mem_op && aligned) : (!dmem_ack && !timeout);
        state_nx = hold ? BUSY : IDLE;
        stall_M  = rst_n && hold;
    end

    assign dmem_we    = cap_we;
    assign dmem_addr  = cap_addr;
    assign dmem_wdata = cap_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_we     <= 1'b0;
            cap_wb     <= '0;
            cap_wreg   <= '0;
            dmem_req   <= 1'b0;
            WB_W       <= '0;
            ReadData_W <= '0;
            ALUOut_W   <= '0;
            WriteReg_W <= '0;
            misalign_W <= 1'b0;
            bus_err_W  <= 1'b0;
        end else begin
            state      <= state_nx;
            misalign_W <= 1'b0;
            bus_err_W  <= 1'b0;
            if (state == IDLE) begin
                if (!mem_op || !aligned) begin
                    // misaligned ops pass through with RegWrite cleared
                    WB_W       <= mem_op ? {1'b0, WB_M[0]} : WB_M;
                    ALUOut_W   <= ALUOut_M;
                    WriteReg_W <= WriteReg_M;
                    ReadData_W <= '0;
                    misalign_W <= mem_op;
                end else begin
                    cap_addr  <= ALUOut_M;
                    cap_wdata <= WriteData_M;
                    cap_we    <= MEM_M[0];
                    cap_wb    <= WB_M;
                    cap_wreg  <= WriteReg_M;
                    dmem_req  <= 1'b1;
                    cnt       <= '0;
                    WB_W      <= '0;
                end
            end else if (dmem_ack) begin
                WB_W       <= cap_wb;
                ALUOut_W   <= cap_addr;
                WriteReg_W <= cap_wreg;
                ReadData_W <= cap_we ? 32'h0 : dmem_rdata;
                dmem_req   <= 1'b0;
            end else if (timeout) begin
                dmem_req  <= 1'b0;
                WB_W      <= '0;
                bus_err_W <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                WB_W <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed-vector bench for mem_stage with hand-computed expectations.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  MEM_M, WB_M;
    logic [31:0] ALUOut_M, WriteData_M;
    logic [4:0]  WriteReg_M;
    logic        stall_M, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [1:0]  WB_W;
    logic [31:0] ReadData_W, ALUOut_W;
    logic [4:0]  WriteReg_W;
    logic        misalign_W, bus_err_W;
    int vecs = 0;
    int errs = 0;

    mem_stage #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .MEM_M(MEM_M), .WB_M(WB_M), .ALUOut_M(ALUOut_M),
        .WriteData_M(WriteData_M), .WriteReg_M(WriteReg_M), .stall_M(stall_M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .WB_W(WB_W), .ReadData_W(ReadData_W), .ALUOut_W(ALUOut_W),
        .WriteReg_W(WriteReg_W), .misalign_W(misalign_W), .bus_err_W(bus_err_W)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] mem, input logic [1:0] wb, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [4:0] rd);
        MEM_M = mem; WB_M = wb; ALUOut_M = alu; WriteData_M = wd; WriteReg_M = rd;
    endtask

    initial begin
        rst_n = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        drive(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
        repeat (2) step();
        chk("rst_req", dmem_req, 0);
        chk("rst_wb", WB_W, 0);
        chk("rst_alu", ALUOut_W, 0);
        chk("rst_rd", ReadData_W, 0);
        chk("rst_flags", {misalign_W, bus_err_W}, 0);
        rst_n = 1'b1;
        // ALU passthrough
        drive(2'b00, 2'b10, 32'h1234, 32'h0, 5'd8);
        @(negedge clk); chk("alu_stall", stall_M, 0);
        step(); drive(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        chk("alu_wb", WB_W, 2'b10);
        chk("alu_out", ALUOut_W, 32'h1234);
        chk("alu_reg", WriteReg_W, 8);
        chk("alu_stall2", stall_M, 0);
        // load at 0x100, ack in cycle 3
        step(); drive(2'b10, 2'b11, 32'h100, 32'h0, 5'd9);
        @(negedge clk); chk("ld_c0_stall", stall_M, 1); chk("ld_c0_req", dmem_req, 0);
        step(); @(negedge clk);
        chk("ld_c1_req", dmem_req, 1); chk("ld_c1_we", dmem_we, 0);
        chk("ld_c1_addr", dmem_addr, 32'h100); chk("ld_c1_stall", stall_M, 1);
        chk("ld_c1_bubble", WB_W, 0);
        step(); @(negedge clk); chk("ld_c2_stall", stall_M, 1); chk("ld_c2_req", dmem_req, 1);
        step(); dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        @(negedge clk); chk("ld_c3_stall", stall_M, 0); chk("ld_c3_req", dmem_req, 1);
        // store back-to-back at 0x200, ack in cycle 1
        step(); dmem_ack = 1'b0; drive(2'b01, 2'b00, 32'h200, 32'hCAFEF00D, 5'd0);
        @(negedge clk);
        chk("ld_rdata", ReadData_W, 32'hDEADBEEF); chk("ld_wb", WB_W, 2'b11);
        chk("ld_alu", ALUOut_W, 32'h100); chk("ld_reg", WriteReg_W, 9);
        chk("ld_req_fall", dmem_req, 0); chk("st_c0_stall", stall_M, 1);
        step(); dmem_ack = 1'b1;
        @(negedge clk);
        chk("st_req", dmem_req, 1); chk("st_we", dmem_we, 1);
        chk("st_wdata", dmem_wdata, 32'hCAFEF00D); chk("st_addr", dmem_addr, 32'h200);
        chk("st_c1_stall", stall_M, 0);
        // misaligned load at 0x102
        step(); dmem_ack = 1'b0; drive(2'b10, 2'b11, 32'h102, 32'h0, 5'd5);
        @(negedge clk);
        chk("st_wb", WB_W, 0); chk("st_rdata", ReadData_W, 0); chk("st_alu", ALUOut_W, 32'h200);
        chk("mis_req", dmem_req, 0); chk("mis_stall", stall_M, 0);
        step(); drive(2'b00, 2'b10, 32'h10, 32'h0, 5'd1);
        @(negedge clk);
        chk("mis_flag", misalign_W, 1); chk("mis_wb", WB_W, 2'b01);
        chk("mis_alu", ALUOut_W, 32'h102); chk("mis_reg", WriteReg_W, 5); chk("mis_req2", dmem_req, 0);
        step(); @(negedge clk);
        chk("mis_flag_clr", misalign_W, 0); chk("mis_next_wb", WB_W, 2'b10);
        // store timeout
        step(); drive(2'b01, 2'b00, 32'h300, 32'h11112222, 5'd0);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk); chk("to_stall", stall_M, 1);
            step();
        end
        @(negedge clk); chk("to_c16_stall", stall_M, 0); chk("to_c16_req", dmem_req, 1);
        step(); drive(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        chk("to_buserr", bus_err_W, 1); chk("to_req", dmem_req, 0); chk("to_wb", WB_W, 0);
        step(); @(negedge clk); chk("to_buserr_clr", bus_err_W, 0);
        // load with ack exactly in cycle 16
        step(); drive(2'b10, 2'b11, 32'h400, 32'h0, 5'd7);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk); chk("ack16_stall", stall_M, 1);
            step();
        end
        dmem_ack = 1'b1; dmem_rdata = 32'h5A5A5A5A;
        @(negedge clk); chk("ack16_c16_stall", stall_M, 0);
        step(); dmem_ack = 1'b0; drive(2'b00, 2'b10, 32'h77, 32'h0, 5'd2);
        @(negedge clk);
        chk("ack16_buserr", bus_err_W, 0); chk("ack16_rdata", ReadData_W, 32'h5A5A5A5A);
        chk("ack16_wb", WB_W, 2'b11); chk("ack16_req", dmem_req, 0);
        // reset in the middle of a pending load
        step(); drive(2'b10, 2'b11, 32'h500, 32'h0, 5'd6);
        @(negedge clk); chk("rl_c0_stall", stall_M, 1);
        step(); @(negedge clk); chk("rl_c1_req", dmem_req, 1);
        step(); rst_n = 1'b0; #1;
        chk("rl_req", dmem_req, 0); chk("rl_stall", stall_M, 0);
        chk("rl_wb", WB_W, 0); chk("rl_alu", ALUOut_W, 0); chk("rl_reg", WriteReg_W, 0);
        step(); drive(2'b00, 2'b10, 32'h55, 32'h0, 5'd3); dmem_ack = 1'b1; rst_n = 1'b1;
        @(negedge clk); chk("post_stall", stall_M, 0); chk("post_req", dmem_req, 0);
        step(); @(negedge clk);
        chk("post_wb", WB_W, 2'b10); chk("post_alu", ALUOut_W, 32'h55);
        chk("post_reg", WriteReg_W, 3); chk("post_rdata", ReadData_W, 0); chk("post_req2", dmem_req, 0);
        dmem_ack = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
